// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game core.
package whack_pkg;

  localparam int unsigned SEG_W    = 3;
  localparam int unsigned SCORE_W  = 8;
  localparam int unsigned LEVEL_W  = 4;
  localparam int unsigned NUM_SEGS = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    OVER = 2'd3
  } sched_state_t;

  // Fold the out-of-range LFSR value onto segment 0 and never repeat the previous mole.
  function automatic logic [SEG_W-1:0] pick_seg(input logic [SEG_W-1:0] rnd,
                                                input logic [SEG_W-1:0] prev);
    logic [SEG_W-1:0] s;
    s = (rnd == SEG_W'(NUM_SEGS)) ? '0 : rnd;
    if (s == prev) begin
      s = (s == SEG_W'(NUM_SEGS - 1)) ? '0 : s + SEG_W'(1);
    end
    return s;
  endfunction

endpackage

// File: rtl/level_tracker.sv
// Counts hits toward the next level and derives the mole-visible window from the level.
module level_tracker
  import whack_pkg::*;
#(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned WIN_INIT       = 2_000_000,
  parameter int unsigned WIN_STEP       = 100_000,
  parameter int unsigned WIN_MIN        = 400_000,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hit,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   window
);

  localparam int unsigned WIDE_W = CNT_W + 4;
  localparam int unsigned HC_W   = 8;

  logic [HC_W-1:0]   hit_cnt;
  logic [WIDE_W-1:0] reduction;
  logic [WIDE_W-1:0] remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
      level   <= '0;
    end else if (clear) begin
      hit_cnt <= '0;
      level   <= '0;
    end else if (hit) begin
      if (hit_cnt == HC_W'(HITS_PER_LEVEL - 1)) begin
        hit_cnt <= '0;
        if (level != '1) level <= level + LEVEL_W'(1);
      end else begin
        hit_cnt <= hit_cnt + HC_W'(1);
      end
    end
  end

  // Widened arithmetic so a large level cannot wrap below the floor.
  always_comb begin
    reduction = WIDE_W'(level) * WIDE_W'(WIN_STEP);
    remaining = '0;
    window    = CNT_W'(WIN_MIN);
    if (reduction < WIDE_W'(WIN_INIT)) begin
      remaining = WIDE_W'(WIN_INIT) - reduction;
      if (remaining > WIDE_W'(WIN_MIN)) window = CNT_W'(remaining);
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Round sequencer: spaces moles by a fixed gap, times each visible window and scores presses.
module mole_scheduler
  import whack_pkg::*;
#(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned WIN_INIT       = 2_000_000,
  parameter int unsigned WIN_STEP       = 100_000,
  parameter int unsigned WIN_MIN        = 400_000,
  parameter int unsigned GAP_CYCLES     = 200_000,
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned MAX_MISSES     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [SEG_W-1:0]   rand_seg,
  input  logic [7:0]         btn_rise,
  output logic               mole_valid,
  output logic [SEG_W-1:0]   mole_seg,
  output logic [LEVEL_W-1:0] level,
  output logic [SCORE_W-1:0] hits,
  output logic [SCORE_W-1:0] misses,
  output logic               wrong_pulse,
  output logic               game_over
);

  sched_state_t       state, state_n;
  logic [CNT_W-1:0]   gap_cnt, gap_n;
  logic [CNT_W-1:0]   win_cnt, win_n;
  logic [CNT_W-1:0]   window;
  logic [SCORE_W-1:0] hits_n, misses_n;
  logic [SCORE_W:0]   miss_inc;
  logic [SEG_W-1:0]   seg_n;
  logic               wrong_n;
  logic               clear;
  logic               hit;

  level_tracker #(
    .CNT_W          (CNT_W),
    .WIN_INIT       (WIN_INIT),
    .WIN_STEP       (WIN_STEP),
    .WIN_MIN        (WIN_MIN),
    .HITS_PER_LEVEL (HITS_PER_LEVEL)
  ) u_level (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .hit    (hit),
    .level  (level),
    .window (window)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      win_cnt     <= '0;
      hits        <= '0;
      misses      <= '0;
      mole_seg    <= '0;
      wrong_pulse <= 1'b0;
      mole_valid  <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      gap_cnt     <= gap_n;
      win_cnt     <= win_n;
      hits        <= hits_n;
      misses      <= misses_n;
      mole_seg    <= seg_n;
      wrong_pulse <= wrong_n;
      mole_valid  <= (state_n == UP);
      game_over   <= (state_n == OVER);
    end
  end

  // start overrides everything; in UP the correct press outranks wrong bits and the timeout.
  always_comb begin
    state_n  = state;
    gap_n    = gap_cnt;
    win_n    = win_cnt;
    hits_n   = hits;
    misses_n = misses;
    seg_n    = mole_seg;
    wrong_n  = 1'b0;
    clear    = 1'b0;
    hit      = 1'b0;
    miss_inc = {1'b0, misses} + (SCORE_W + 1)'(1);
    if (start) begin
      clear    = 1'b1;
      hits_n   = '0;
      misses_n = '0;
      gap_n    = CNT_W'(GAP_CYCLES);
      state_n  = GAP;
    end else begin
      case (state)
        GAP: begin
          if (stop) begin
            state_n = OVER;
          end else if (gap_cnt == '0) begin
            seg_n   = pick_seg(rand_seg, mole_seg);
            win_n   = window;
            state_n = UP;
          end else begin
            gap_n = gap_cnt - CNT_W'(1);
          end
        end
        UP: begin
          if (stop) begin
            state_n = OVER;
          end else if (btn_rise[mole_seg]) begin
            hit     = (hits != '1);
            hits_n  = (hits == '1) ? hits : hits + SCORE_W'(1);
            gap_n   = CNT_W'(GAP_CYCLES);
            state_n = GAP;
          end else if (|btn_rise) begin
            wrong_n = 1'b1;
          end else if (win_cnt <= CNT_W'(1)) begin
            misses_n = (misses == '1) ? misses : miss_inc[SCORE_W-1:0];
            gap_n    = CNT_W'(GAP_CYCLES);
            state_n  = (miss_inc >= (SCORE_W + 1)'(MAX_MISSES)) ? OVER : GAP;
          end else begin
            win_n = win_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed scenarios for mole_scheduler with small window/gap parameters.
module tb_mole_scheduler;
  import whack_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic [SEG_W-1:0]   rand_seg;
  logic [7:0]         btn_rise;
  logic               mole_valid;
  logic [SEG_W-1:0]   mole_seg;
  logic [LEVEL_W-1:0] level;
  logic [SCORE_W-1:0] hits;
  logic [SCORE_W-1:0] misses;
  logic               wrong_pulse;
  logic               game_over;

  int checks = 0;
  int errors = 0;
  logic [SEG_W-1:0] prev_seg;

  mole_scheduler #(
    .CNT_W          (24),
    .WIN_INIT       (20),
    .WIN_STEP       (4),
    .WIN_MIN        (8),
    .GAP_CYCLES     (3),
    .HITS_PER_LEVEL (2),
    .MAX_MISSES     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .rand_seg    (rand_seg),
    .btn_rise    (btn_rise),
    .mole_valid  (mole_valid),
    .mole_seg    (mole_seg),
    .level       (level),
    .hits        (hits),
    .misses      (misses),
    .wrong_pulse (wrong_pulse),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [SEG_W-1:0] model_seg(input logic [SEG_W-1:0] r,
                                                 input logic [SEG_W-1:0] prev);
    int s;
    s = (r == 3'd7) ? 0 : int'(r);
    if (s == int'(prev)) s = (s + 1) % 7;
    return 3'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_mole(input string name);
    for (int i = 0; i < 60 && !mole_valid; i++) tick();
    checks++;
    if (mole_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: mole never appeared, mole_valid=%b required 1", name, mole_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; rand_seg = 3'd0; btn_rise = 8'h00;
    tick(); tick();
    checks++;
    if ({mole_valid, mole_seg, level, hits, misses, wrong_pulse, game_over} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b seg=%0d lvl=%0d hits=%0d misses=%0d wrong=%b over=%b required all 0",
               mole_valid, mole_seg, level, hits, misses, wrong_pulse, game_over);
    end
    rst = 1'b0;
    prev_seg = 3'd0;
    tick();
  endtask

  task automatic test_timeout_window();
    int hi_cnt;
    rand_seg = 3'd3;
    pulse_start();
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (mole_valid) hi_cnt++;
      tick();
    end
    checks++;
    if (hi_cnt != 0) begin errors++; $display("FAIL gap_blank: lit cycles=%0d required 0", hi_cnt); end
    prev_seg = model_seg(3'd3, prev_seg);
    for (int i = 0; i < 20; i++) begin
      if (mole_valid) hi_cnt++;
      tick();
    end
    checks++;
    if (hi_cnt != 20) begin errors++; $display("FAIL window_len: lit cycles=%0d required 20", hi_cnt); end
    checks++;
    if (mole_valid !== 1'b0 || misses !== 8'd1) begin
      errors++;
      $display("FAIL first_miss: valid=%b misses=%0d required 0/1", mole_valid, misses);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mole_valid) hi_cnt++;
    end
    tick();
    prev_seg = model_seg(3'd3, prev_seg);
    checks++;
    if (hi_cnt != 20 || mole_valid !== 1'b1) begin
      errors++;
      $display("FAIL second_mole: valid=%b extra_lit=%0d required 1/0", mole_valid, hi_cnt - 20);
    end
  endtask

  task automatic test_hits_levels();
    logic [SEG_W-1:0] rv [10] = '{3'd3, 3'd3, 3'd7, 3'd0, 3'd5, 3'd6, 3'd6, 3'd2, 3'd1, 3'd7};
    int wins [10] = '{20, 20, 16, 16, 12, 12, 8, 8, 8, 8};
    int lit;
    rand_seg = rv[0];
    pulse_start();
    for (int m = 0; m < 10; m++) begin
      wait_mole("hit_mole");
      prev_seg = model_seg(rv[m], prev_seg);
      checks++;
      if (mole_seg !== prev_seg) begin
        errors++;
        $display("FAIL hit_seg[%0d]: seg=%0d required %0d", m, mole_seg, prev_seg);
      end
      lit = 0;
      for (int j = 1; j < wins[m]; j++) begin
        if (mole_valid) lit++;
        tick();
      end
      if (mole_valid) lit++;
      btn_rise = 8'(1 << prev_seg);
      tick();
      btn_rise = 8'h00;
      if (m < 9) rand_seg = rv[m+1];
      checks++;
      if (lit != wins[m] || hits !== 8'(m + 1) || mole_valid !== 1'b0) begin
        errors++;
        $display("FAIL hit_window[%0d]: lit=%0d hits=%0d valid=%b required %0d/%0d/0",
                 m, lit, hits, mole_valid, wins[m], m + 1);
      end
    end
    checks++;
    if (hits !== 8'd10 || level !== 4'd5 || misses !== 8'd0) begin
      errors++;
      $display("FAIL level_final: hits=%0d level=%0d misses=%0d required 10/5/0", hits, level, misses);
    end
  endtask

  task automatic test_wrong_press();
    rand_seg = 3'd2;
    pulse_start();
    checks++;
    if (level !== 4'd0 || hits !== 8'd0 || misses !== 8'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: level=%0d hits=%0d misses=%0d over=%b required 0", level, hits, misses, game_over);
    end
    wait_mole("wrong_mole");
    prev_seg = model_seg(3'd2, prev_seg);
    btn_rise = 8'h80;
    tick();
    btn_rise = 8'h00;
    checks++;
    if (wrong_pulse !== 1'b1 || hits !== 8'd0 || misses !== 8'd0 || mole_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrong_press: wrong=%b hits=%0d misses=%0d valid=%b required 1/0/0/1",
               wrong_pulse, hits, misses, mole_valid);
    end
    tick();
    checks++;
    if (wrong_pulse !== 1'b0 || mole_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrong_one_cycle: wrong=%b valid=%b required 0/1", wrong_pulse, mole_valid);
    end
    btn_rise = 8'(1 << prev_seg);
    tick();
    btn_rise = 8'h00;
    checks++;
    if (hits !== 8'd1 || mole_valid !== 1'b0 || wrong_pulse !== 1'b0) begin
      errors++;
      $display("FAIL wrong_then_hit: hits=%0d valid=%b wrong=%b required 1/0/0", hits, mole_valid, wrong_pulse);
    end
  endtask

  task automatic test_simultaneous();
    rand_seg = 3'd5;
    pulse_start();
    wait_mole("simul_mole");
    prev_seg = model_seg(3'd5, prev_seg);
    for (int j = 1; j < 20; j++) tick();
    btn_rise = 8'(1 << prev_seg) | 8'h80;
    tick();
    btn_rise = 8'h00;
    checks++;
    if (hits !== 8'd1 || misses !== 8'd0 || wrong_pulse !== 1'b0 || mole_valid !== 1'b0) begin
      errors++;
      $display("FAIL last_cycle_combo: hits=%0d misses=%0d wrong=%b valid=%b required 1/0/0/0",
               hits, misses, wrong_pulse, mole_valid);
    end
  endtask

  task automatic test_game_over_restart();
    rand_seg = 3'd1;
    pulse_start();
    for (int i = 0; i < 71; i++) tick();
    for (int i = 0; i < 3; i++) prev_seg = model_seg(3'd1, prev_seg);
    checks++;
    if (game_over !== 1'b0 || mole_valid !== 1'b1 || misses !== 8'd2) begin
      errors++;
      $display("FAIL before_over: over=%b valid=%b misses=%0d required 0/1/2", game_over, mole_valid, misses);
    end
    tick();
    checks++;
    if (game_over !== 1'b1 || mole_valid !== 1'b0 || misses !== 8'd3) begin
      errors++;
      $display("FAIL game_over: over=%b valid=%b misses=%0d required 1/0/3", game_over, mole_valid, misses);
    end
    tick(); tick();
    btn_rise = 8'hFF;
    tick();
    btn_rise = 8'h00;
    checks++;
    if (game_over !== 1'b1 || misses !== 8'd3 || hits !== 8'd0 || wrong_pulse !== 1'b0) begin
      errors++;
      $display("FAIL over_hold: over=%b misses=%0d hits=%0d wrong=%b required 1/3/0/0",
               game_over, misses, hits, wrong_pulse);
    end
    pulse_start();
    checks++;
    if (game_over !== 1'b0 || mole_valid !== 1'b0 || hits !== 8'd0 || misses !== 8'd0 || level !== 4'd0) begin
      errors++;
      $display("FAIL over_restart: over=%b valid=%b hits=%0d misses=%0d level=%0d required all 0",
               game_over, mole_valid, hits, misses, level);
    end
  endtask

  task automatic test_stop_priority();
    rand_seg = 3'd4;
    pulse_start();
    wait_mole("stop_mole");
    prev_seg = model_seg(3'd4, prev_seg);
    btn_rise = 8'(1 << prev_seg);
    stop = 1'b1;
    tick();
    btn_rise = 8'h00;
    stop = 1'b0;
    checks++;
    if (game_over !== 1'b1 || mole_valid !== 1'b0 || hits !== 8'd0) begin
      errors++;
      $display("FAIL stop_beats_hit: over=%b valid=%b hits=%0d required 1/0/0", game_over, mole_valid, hits);
    end
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (game_over !== 1'b0 || mole_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_beats_stop: over=%b valid=%b required 0/0", game_over, mole_valid);
    end
  endtask

  task automatic test_seg_pick();
    logic [SEG_W-1:0] rv  [6] = '{3'd4, 3'd7, 3'd0, 3'd1, 3'd6, 3'd6};
    logic [SEG_W-1:0] exp [6] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd6, 3'd0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rand_seg = rv[0];
    pulse_start();
    for (int m = 0; m < 6; m++) begin
      wait_mole("seg_mole");
      checks++;
      if (mole_seg !== exp[m]) begin
        errors++;
        $display("FAIL seg_pick[%0d]: rand=%0d seg=%0d required %0d", m, rv[m], mole_seg, exp[m]);
      end
      btn_rise = 8'(1 << exp[m]);
      tick();
      btn_rise = 8'h00;
      if (m < 5) rand_seg = rv[m+1];
    end
    checks++;
    if (hits !== 8'd6 || level !== 4'd3) begin
      errors++;
      $display("FAIL seg_hits: hits=%0d level=%0d required 6/3", hits, level);
    end
  endtask

  task automatic test_midround_reset();
    rand_seg = 3'd2;
    pulse_start();
    wait_mole("reset_mole");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({mole_valid, mole_seg, level, hits, misses, wrong_pulse, game_over} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b seg=%0d lvl=%0d hits=%0d misses=%0d over=%b required all 0",
               mole_valid, mole_seg, level, hits, misses, game_over);
    end
    #3 rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (mole_valid !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%b over=%b required 0/0", mole_valid, game_over);
    end
  endtask

  initial begin
    test_reset();
    test_timeout_window();
    test_hits_levels();
    test_wrong_press();
    test_simultaneous();
    test_game_over_restart();
    test_stop_priority();
    test_seg_pick();
    test_midround_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Round sequencer for the whack-a-mole game core. It decides when a mole appears, which segment it lights, and how long it stays lit. Each mole is scored as a hit, a miss or a wrong press, and the visible window shrinks as the level rises. It sits between the LFSR/debounce front end and the 7-segment driver, and drives the target segment and the score counters.

## Interface
Parameters:
- CNT_W, 24: width of the gap and window counters.
- WIN_INIT, 2_000_000: mole-visible window at level 0, in cycles.
- WIN_STEP, 100_000: window reduction per level, in cycles.
- WIN_MIN, 400_000: floor for the window, in cycles.
- GAP_CYCLES, 200_000: blank cycles between moles.
- HITS_PER_LEVEL, 4: hits needed per level increment.
- MAX_MISSES, 5: miss count that ends the game.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: reset, asynchronous and active-high.
- start, input, 1: one-cycle pulse that begins or restarts a game.
- stop, input, 1: level input; external game_end from the timer.
- rand_seg, input, 3: free-running LFSR value.
- btn_rise, input, 8: one-cycle press pulses, already debounced and lockout-masked.
- mole_valid, output, 1: a mole is currently lit.
- mole_seg, output, 3: target segment, 0..6.
- level, output, 4: current level, saturating at 15.
- hits, output, 8: hit count, saturating at 255.
- misses, output, 8: miss count, saturating at 255.
- wrong_pulse, output, 1: one-cycle pulse on a wrong press.
- game_over, output, 1: the game has ended.

## Operation
- States: IDLE, GAP, UP, OVER. Reset enters IDLE.
- Reset value of every output is 0.
- IDLE, on start:
  - Clear hits, misses and level.
  - Load the gap counter with GAP_CYCLES.
  - Go to GAP.
- GAP:
  - Decrement the gap counter every cycle.
  - At counter == 0, latch the segment, load the window counter with the current window, and go to UP.
- Segment pick:
  - s = (rand_seg == 7) ? 0 : rand_seg.
  - If s equals the previous mole_seg, use (s + 1) mod 7.
- Window:
  - window = max(WIN_INIT − level·WIN_STEP, WIN_MIN).
  - Compute at CNT_W+4 bits, with no underflow.
- UP, priority high to low:
  1. stop: go to OVER.
  2. btn_rise[mole_seg]: hits += 1; go to GAP.
  3. Other btn_rise bits: pulse wrong_pulse for one cycle and stay in UP. Counters are unchanged.
  4. Window counter == 1: misses += 1; go to GAP, or to OVER if misses + 1 ≥ MAX_MISSES.
  - Otherwise decrement the window counter.
- Level:
  - Increments on each hit that makes hits a multiple of HITS_PER_LEVEL.
  - Saturates at 15.
  - The new window applies from the next mole.
- stop in GAP: go to OVER.
- OVER:
  - game_over = 1 and mole_valid = 0.
  - Counters are held.
  - start restarts exactly as from IDLE.
- start in GAP or UP aborts the round and restarts (clear counters, enter GAP).
- mole_valid = (state == UP). All outputs are registered.

## Timing
- start sampled at cycle t gives state GAP for cycles t+1 .. t+1+GAP_CYCLES.
- mole_valid rises at cycle t+2+GAP_CYCLES.
- mole_valid is high for exactly `window` cycles with no press.
- A press in the final UP cycle counts as a hit, not a miss.
- hits and misses update in the cycle after the qualifying event. mole_valid falls in that same cycle.
- btn_rise when not in UP is ignored.
- Simultaneous events:
  - Correct and wrong bits together count as a hit.
  - stop together with a hit: stop wins and the hit is not counted.
  - start together with stop: start wins.
- rst asserted mid-round: all outputs go to 0 immediately and the state is IDLE.

## Structure
- Shared package whack_pkg holds:
  - the sched_state_t enum (IDLE, GAP, UP, OVER);
  - the SEG_W = 3, SCORE_W = 8 and LEVEL_W = 4 constants;
  - the NUM_SEGS = 7 constant.
- Sub-module level_tracker: holds the hit-since-level count and the level register, and outputs the window value combinationally.

## Test plan
Parameters for all scenarios: WIN_INIT=20, WIN_STEP=4, WIN_MIN=8, GAP_CYCLES=3, HITS_PER_LEVEL=2, MAX_MISSES=3.
- Start pulse at cycle 10, no presses → mole_valid high cycles 15..34; misses=1 at cycle 35; mole_valid rises again at cycle 39.
- Hit within each window, 10 times → hits=10, level=5; window trace 20, 20, 16, 16, 12, 12, 8, 8, 8, 8.
- Wrong button in UP → one wrong_pulse; hits and misses unchanged; mole stays lit until the correct press.
- Correct and wrong bits together on the last UP cycle → hits+1, misses unchanged, no wrong_pulse.
- Three consecutive timeouts → game_over=1 and mole_valid=0 after the third; a start pulse then gives hits=misses=level=0 and GAP.
- stop asserted with a correct press in UP → OVER, hits unchanged. Forced rand_seg=7 → mole_seg=0; a repeated value → mole_seg is the previous value + 1 mod 7.
